// File: rtl/usb_bit_stuff_pkg.sv
// Shared constants and types for the USB bit-stuffing engine and its run counter.
package usb_bit_stuff_pkg;
  localparam int DEFAULT_RUN_LENGTH = 6;
  localparam int MAX_RUN_LENGTH     = 15;

  typedef logic [3:0] ones_cnt_t;
endpackage

// File: rtl/usb_ones_run_counter.sv
// Saturating counter of consecutive ones. It can restart from zero and count the
// current bit in the same cycle.
module usb_ones_run_counter
  import usb_bit_stuff_pkg::*;
#(
  parameter int RUN_LENGTH = DEFAULT_RUN_LENGTH,
  parameter int CNT_W      = $clog2(RUN_LENGTH + 1)
) (
  input  logic clk12,
  input  logic RST,
  input  logic clr,
  input  logic zero,
  input  logic inc,
  output logic atLimit
);

  localparam ones_cnt_t       LIMIT_FULL = ones_cnt_t'(RUN_LENGTH);
  localparam logic [CNT_W-1:0] LIMIT     = LIMIT_FULL[CNT_W-1:0];

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_base;

  // 'zero' restarts the run. A set 'inc' then counts the current bit from 0.
  always_comb begin
    w_base = zero ? '0 : r_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk12 or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (w_base != LIMIT)) begin
      r_cnt <= w_base + CNT_W'(1);
    end else begin
      r_cnt <= w_base;
    end
  end

  assign atLimit = (r_cnt == LIMIT);

endmodule

// File: rtl/usb_bit_stuff_engine.sv
// Bit stuffing (TX) and unstuffing (RX) for the SIE bit path, one bit per clk12.
// The data path is combinational. The run counter, the mode flag and the error flag are registered.
module usb_bit_stuff_engine
  import usb_bit_stuff_pkg::*;
#(
  parameter int RUN_LENGTH   = DEFAULT_RUN_LENGTH,
  parameter int ERROR_STICKY = 0,
  parameter int CNT_W        = $clog2(RUN_LENGTH + 1)
) (
  input  logic clk12,
  input  logic RST,
  input  logic clear,
  input  logic isSendingPhase,
  input  logic bitValid,
  input  logic dataIn,
  output logic ready_valid,
  output logic dataOut,
  output logic stuffEvent,
  output logic error
);

  if (RUN_LENGTH < 2 || RUN_LENGTH > MAX_RUN_LENGTH) begin : g_bad_run_length
    $error("usb_bit_stuff_engine: RUN_LENGTH must be in 2..15");
  end

  logic r_prev_mode;
  logic w_at_limit;
  logic w_mode_chg;
  logic w_stuff_slot;
  logic w_valid;
  logic w_inc;
  logic w_zero;
  logic w_err_set;

  // The first cycle after a mode switch behaves as if the run counter were 0.
  assign w_mode_chg   = isSendingPhase ^ r_prev_mode;
  assign w_stuff_slot = w_at_limit & ~w_mode_chg;
  assign w_valid      = bitValid & RST;

  usb_ones_run_counter #(
    .RUN_LENGTH (RUN_LENGTH),
    .CNT_W      (CNT_W)
  ) u_run_counter (
    .clk12   (clk12),
    .RST     (RST),
    .clr     (clear),
    .zero    (w_zero),
    .inc     (w_inc),
    .atLimit (w_at_limit)
  );

  // NOTE: every output of this block gets a default first, so no path through
  // the branches can infer a latch.
  always_comb begin
    ready_valid = 1'b0;
    dataOut     = 1'b0;
    stuffEvent  = 1'b0;
    w_inc       = 1'b0;
    w_zero      = w_mode_chg;
    w_err_set   = 1'b0;
    if (isSendingPhase && w_stuff_slot) begin
      // The stuff zero goes out even without a valid bit. The serializer holds its bit.
      stuffEvent = 1'b1;
      w_zero     = 1'b1;
    end else if (!isSendingPhase && w_valid && w_stuff_slot) begin
      w_zero = 1'b1;
      if (dataIn) begin
        w_err_set = 1'b1;
      end else begin
        stuffEvent = 1'b1;
      end
    end else if (w_valid) begin
      ready_valid = 1'b1;
      dataOut     = dataIn;
      w_inc       = dataIn;
      w_zero      = ~dataIn | w_mode_chg;
    end
  end

  always_ff @(posedge clk12 or negedge RST) begin
    if (!RST) begin
      r_prev_mode <= 1'b0;
    end else begin
      r_prev_mode <= isSendingPhase;
    end
  end

  always_ff @(posedge clk12 or negedge RST) begin
    if (!RST) begin
      error <= 1'b0;
    end else if (clear) begin
      error <= 1'b0;
    end else if (w_err_set) begin
      error <= 1'b1;
    end else if (ERROR_STICKY == 0) begin
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_bit_stuff_engine.sv
// Self-checking bench for usb_bit_stuff_engine: three instances (RL6, RL6 sticky,
// RL3) share the stimulus. Each sequence is checked against the instance it targets.
module tb_usb_bit_stuff_engine;

  logic       clk12 = 1'b0;
  logic       RST;
  logic       clear;
  logic       isSendingPhase;
  logic       bitValid;
  logic       dataIn;
  logic [2:0] rv;
  logic [2:0] dout;
  logic [2:0] se;
  logic [2:0] err;

  always #5 clk12 = ~clk12;

  usb_bit_stuff_engine #(.RUN_LENGTH(6), .ERROR_STICKY(0)) dut_rl6 (
    .clk12(clk12), .RST(RST), .clear(clear), .isSendingPhase(isSendingPhase),
    .bitValid(bitValid), .dataIn(dataIn), .ready_valid(rv[0]), .dataOut(dout[0]),
    .stuffEvent(se[0]), .error(err[0])
  );

  usb_bit_stuff_engine #(.RUN_LENGTH(6), .ERROR_STICKY(1)) dut_rl6_sticky (
    .clk12(clk12), .RST(RST), .clear(clear), .isSendingPhase(isSendingPhase),
    .bitValid(bitValid), .dataIn(dataIn), .ready_valid(rv[1]), .dataOut(dout[1]),
    .stuffEvent(se[1]), .error(err[1])
  );

  usb_bit_stuff_engine #(.RUN_LENGTH(3), .ERROR_STICKY(0)) dut_rl3 (
    .clk12(clk12), .RST(RST), .clear(clear), .isSendingPhase(isSendingPhase),
    .bitValid(bitValid), .dataIn(dataIn), .ready_valid(rv[2]), .dataOut(dout[2]),
    .stuffEvent(se[2]), .error(err[2])
  );

  // Expected output encoding: {ready_valid, dataOut, stuffEvent, error}
  localparam logic [3:0] P1 = 4'b1100;  // payload 1
  localparam logic [3:0] P0 = 4'b1000;  // payload 0
  localparam logic [3:0] ST = 4'b0010;  // stuff inserted/removed
  localparam logic [3:0] NO = 4'b0000;  // nothing
  localparam logic [3:0] ER = 4'b0001;  // error flag

  typedef struct {
    logic       snd;
    logic       vld;
    logic       din;
    logic       clr;
    logic [3:0] exp;
  } vec_t;

  vec_t       rows[$];
  logic [3:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rv,do,se,err}=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic add(input logic snd, input logic vld, input logic din,
                     input logic clr, input logic [3:0] exp);
    vec_t v;
    v.snd = snd; v.vld = vld; v.din = din; v.clr = clr; v.exp = exp;
    rows.push_back(v);
  endtask

  task automatic add_n(input int n, input logic snd, input logic vld, input logic din,
                       input logic [3:0] exp);
    for (int k = 0; k < n; k++) add(snd, vld, din, 1'b0, exp);
  endtask

  task automatic apply(input int sel, input string name);
    logic [3:0] act;
    logic [3:0] exp;
    for (int i = 0; i < rows.size(); i++) begin
      @(negedge clk12);
      isSendingPhase = rows[i].snd;
      bitValid       = rows[i].vld;
      dataIn         = rows[i].din;
      clear          = rows[i].clr;
      sb_q.push_back(rows[i].exp);
      #4;
      act = {rv[sel], dout[sel], se[sel], err[sel]};
      exp = sb_q.pop_front();
      check($sformatf("%s[%0d]", name, i), act, exp);
    end
    rows.delete();
  endtask

  // Asserts reset asynchronously and checks outputs while it is held.
  // bitValid=1/dataIn=1 in RX must still give all-zero outputs.
  task automatic do_reset(input int sel, input string name);
    @(negedge clk12);
    #1;
    RST = 1'b0; isSendingPhase = 1'b0; bitValid = 1'b1; dataIn = 1'b1; clear = 1'b0;
    #2;
    check({name, "_in_reset"}, {rv[sel], dout[sel], se[sel], err[sel]}, NO);
    @(negedge clk12);
    bitValid = 1'b0;
    RST      = 1'b1;
  endtask

  initial begin
    RST = 1'b0; clear = 1'b0; isSendingPhase = 1'b0; bitValid = 1'b0; dataIn = 1'b0;

    // RX: six ones, stuffed zero removed, then a payload one
    do_reset(0, "rx_stuff");
    add_n(6, 0, 1, 1, P1); add(0, 1, 0, 0, ST); add(0, 1, 1, 0, P1);
    apply(0, "rx_stuff");

    // RX violation, pulse mode: one cycle of error, then clear
    do_reset(0, "rx_viol");
    add_n(6, 0, 1, 1, P1); add(0, 1, 1, 0, NO); add(0, 1, 0, 0, P0 | ER);
    add(0, 1, 0, 0, P0); add(0, 1, 0, 1, P0); add(0, 1, 0, 0, P0);
    apply(0, "rx_viol");

    // Same stimulus, sticky instance: error holds until clear
    do_reset(1, "rx_viol_sticky");
    add_n(6, 0, 1, 1, P1); add(0, 1, 1, 0, NO); add(0, 1, 0, 0, P0 | ER);
    add(0, 1, 0, 0, P0 | ER); add(0, 1, 0, 1, P0 | ER); add(0, 1, 0, 0, P0);
    // a second violation, then reset must drop the sticky error at once
    add_n(6, 0, 1, 1, P1); add(0, 1, 1, 0, NO); add(0, 0, 0, 0, ER); add(0, 0, 0, 0, ER);
    apply(1, "rx_viol_sticky");
    do_reset(1, "sticky_err_reset");

    // TX: eight payload ones, stuff zero on cycle 7, held bit consumed on cycle 8
    do_reset(0, "tx_stuff");
    add_n(6, 1, 1, 1, P1); add(1, 1, 1, 0, ST); add_n(2, 1, 1, 1, P1);
    apply(0, "tx_stuff");

    // TX: gap in bitValid holds the counter
    do_reset(0, "tx_gap");
    add_n(5, 1, 1, 1, P1); add_n(3, 1, 0, 1, NO); add(1, 1, 1, 0, P1);
    add(1, 1, 1, 0, ST); add(1, 1, 1, 0, P1);
    apply(0, "tx_gap");

    // TX: stuff zero is emitted even when bitValid is low
    do_reset(0, "tx_stuff_novalid");
    add_n(6, 1, 1, 1, P1); add(1, 0, 0, 0, ST); add(1, 1, 1, 0, P1);
    apply(0, "tx_stuff_novalid");

    // RX: bitValid gap holds the counter in receive mode too
    do_reset(0, "rx_gap");
    add_n(5, 0, 1, 1, P1); add_n(2, 0, 0, 1, NO); add(0, 1, 1, 0, P1); add(0, 1, 0, 0, ST);
    apply(0, "rx_gap");

    // Mode change clears the run: five RX ones, then six TX ones before the stuff
    do_reset(0, "mode_chg");
    add_n(5, 0, 1, 1, P1); add_n(6, 1, 1, 1, P1); add(1, 1, 1, 0, ST);
    apply(0, "mode_chg");

    // Reset mid-run discards the partial run
    do_reset(0, "mid_reset");
    add_n(3, 0, 1, 1, P1);
    apply(0, "mid_reset_pre");
    do_reset(0, "mid_reset");
    add_n(6, 0, 1, 1, P1); add(0, 1, 0, 0, ST);
    apply(0, "mid_reset_post");

    // Clear wins over increment; the clear cycle's outputs use the old count
    do_reset(0, "clear_prio");
    add_n(5, 0, 1, 1, P1); add(0, 1, 1, 1, P1); add_n(6, 0, 1, 1, P1); add(0, 1, 0, 0, ST);
    apply(0, "clear_prio");

    // RUN_LENGTH=3: TX six ones, then RX of the resulting line stream
    do_reset(2, "rl3");
    add_n(3, 1, 1, 1, P1); add(1, 1, 1, 0, ST); add_n(3, 1, 1, 1, P1); add(1, 1, 1, 0, ST);
    add_n(3, 0, 1, 1, P1); add(0, 1, 0, 0, ST); add_n(3, 0, 1, 1, P1); add(0, 1, 0, 0, ST);
    add(0, 0, 0, 0, NO);
    apply(2, "rl3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
